// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: op codes, error codes, FSM states.
package mem_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  // Op code 11 is reserved and behaves like a non-memory op.
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/ack data-memory port,
// registered writeback bundle, upstream stall while an access is outstanding.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [1:0]        mem_op,
  input  logic [4:0]        rd,
  input  logic              reg_write,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        err,
  output mem_state_e        dbg_state
);

  // Handshake: dmem_req rises with address/data/we and all of them stay
  // stable until the cycle dmem_ack is sampled high; that cycle completes the
  // access. Upstream may change its bundle only in cycles where stall is 0.

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic              rw_lat_q, rw_lat_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [1:0]        err_q, err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_lat_d     = rd_lat_q;
    rw_lat_d     = rw_lat_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    err_d        = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_mem_op(mem_op)) begin
            wb_valid_d = 1'b1;
            wb_we_d    = reg_write;
            wb_rd_d    = rd;
            wb_data_d  = ex_result;
          end else if (ex_result[1:0] != 2'b00) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd;
            wb_data_d  = '0;
            err_d      = ERR_MISALIGN;
          end else begin
            // dmem_we_q doubles as the latched op for the whole access.
            state_d      = ST_ACCESS;
            cnt_d        = '0;
            rd_lat_d     = rd;
            rw_lat_d     = reg_write;
            dmem_req_d   = 1'b1;
            dmem_we_d    = (mem_op == MEM_STORE);
            dmem_addr_d  = ex_result;
            dmem_wdata_d = store_data;
          end
        end
      end

      ST_ACCESS: begin
        // Ack is checked first so a response in the last allowed cycle still completes.
        if (dmem_ack) begin
          state_d    = ST_IDLE;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_lat_q;
          if (dmem_we_q) begin
            wb_we_d   = 1'b0;
            wb_data_d = '0;
          end else begin
            wb_we_d   = rw_lat_q;
            wb_data_d = dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_lat_q;
          wb_data_d  = '0;
          err_d      = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_lat_q     <= '0;
      rw_lat_q     <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      err_q        <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_lat_q     <= rd_lat_d;
      rw_lat_q     <= rw_lat_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      err_q        <= err_d;
    end
  end

  assign stall      = (state_q == ST_ACCESS);
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: drivers push expected writebacks into a queue,
// a negedge monitor pops and compares whenever wb_valid is seen.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int W  = 32;
  localparam int TO = 4;
  localparam int EW = 41; // {check_rd_data, we, rd[4:0], data[31:0], err[1:0]}

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  ex_result;
  logic [W-1:0]  store_data;
  logic [1:0]    mem_op;
  logic [4:0]    rd;
  logic          reg_write;
  logic          stall;
  logic          dmem_req;
  logic          dmem_we;
  logic [W-1:0]  dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic [W-1:0]  dmem_rdata;
  logic          dmem_ack;
  logic          wb_valid;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [W-1:0]  wb_data;
  logic [1:0]    err;
  mem_state_e    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  mem_stage #(.DATA_W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .ex_result  (ex_result),
    .store_data (store_data),
    .mem_op     (mem_op),
    .rd         (rd),
    .reg_write  (reg_write),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic full, input logic we, input logic [4:0] r,
                                             input logic [W-1:0] d, input logic [1:0] e);
    return {full, we, r, d, e};
  endfunction

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wb_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%0h, expected no writeback", wb_rd, wb_data);
          end else begin
            e = exp_q.pop_front();
            check("wb_we", wb_we, e[39]);
            check("wb_err", err, e[1:0]);
            if (e[40]) begin
              check("wb_rd", wb_rd, e[38:34]);
              check("wb_data", wb_data, e[33:2]);
            end
          end
        end else if (err !== ERR_NONE) begin
          checks++;
          errors++;
          $display("FAIL err_without_wb: got err=%0b, expected 00", err);
        end
      end
    end
  end

  // Driver tasks
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    mem_op   = MEM_NONE;
  endtask

  task automatic passthrough(input logic [1:0] op, input logic [W-1:0] val,
                             input logic [4:0] r, input logic rw);
    @(negedge clk);
    check("pt_stall", stall, 1'b0);
    in_valid  = 1'b1;
    mem_op    = op;
    ex_result = val;
    rd        = r;
    reg_write = rw;
    exp_q.push_back(pack_exp(1'b1, rw, r, val, ERR_NONE));
  endtask

  task automatic misaligned(input logic [1:0] op, input logic [W-1:0] addr, input logic [4:0] r);
    @(negedge clk);
    in_valid  = 1'b1;
    mem_op    = op;
    ex_result = addr;
    store_data = 32'h1111_2222;
    rd        = r;
    reg_write = 1'b1;
    exp_q.push_back(pack_exp(1'b0, 1'b0, 5'd0, '0, ERR_MISALIGN));
    @(negedge clk);
    in_valid = 1'b0;
    mem_op   = MEM_NONE;
    check("mis_no_req", dmem_req, 1'b0);
    check("mis_no_stall", stall, 1'b0);
  endtask

  // ack_wait: ACCESS cycles before ack (0 = zero wait), negative = never ack.
  // chain: present a passthrough bundle while stalled; it must be taken on release.
  task automatic mem_access(input logic [1:0] op, input logic [W-1:0] addr, input logic [W-1:0] sdata,
                            input logic [4:0] r, input logic rw, input int ack_wait,
                            input logic [W-1:0] rdata, input logic chain);
    int n;
    int exp_n;
    logic stable;
    @(negedge clk);
    in_valid   = 1'b1;
    mem_op     = op;
    ex_result  = addr;
    store_data = sdata;
    rd         = r;
    reg_write  = rw;
    if (ack_wait < 0)
      exp_q.push_back(pack_exp(1'b0, 1'b0, 5'd0, '0, ERR_TIMEOUT));
    else if (op == MEM_STORE)
      exp_q.push_back(pack_exp(1'b1, 1'b0, r, '0, ERR_NONE));
    else
      exp_q.push_back(pack_exp(1'b1, rw, r, rdata, ERR_NONE));
    @(negedge clk);
    if (chain) begin
      mem_op     = MEM_NONE;
      ex_result  = 32'h5555_0000;
      store_data = 32'h0;
      rd         = 5'd9;
      reg_write  = 1'b1;
      exp_q.push_back(pack_exp(1'b1, 1'b1, 5'd9, 32'h5555_0000, ERR_NONE));
    end else begin
      in_valid = 1'b0;
      mem_op   = MEM_NONE;
    end
    check("req_high", dmem_req, 1'b1);
    check("req_addr", dmem_addr, addr);
    check("req_we", dmem_we, (op == MEM_STORE));
    if (op == MEM_STORE) check("req_wdata", dmem_wdata, sdata);
    n = 0;
    stable = 1'b1;
    while (stall === 1'b1 && n < 64) begin
      if (dmem_req !== 1'b1 || dmem_addr !== addr || dmem_we !== (op == MEM_STORE)) stable = 1'b0;
      dmem_ack   = (n == ack_wait);
      dmem_rdata = (n == ack_wait) ? rdata : 32'hBAD0_BAD0;
      n++;
      @(negedge clk);
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    exp_n = (ack_wait >= 0) ? ack_wait + 1 : TO;
    check("stall_cycles", n, exp_n);
    check("req_stable", stable, 1'b1);
    check("req_dropped", dmem_req, 1'b0);
    if (chain) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Main sequence
  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    ex_result  = '0;
    store_data = '0;
    mem_op     = MEM_NONE;
    rd         = '0;
    reg_write  = 1'b0;
    dmem_rdata = '0;
    dmem_ack   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_req", dmem_req, 1'b0);
    check("rst_we", dmem_we, 1'b0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_err", err, 2'b00);
    reset = 1'b1;

    // Passthrough, then back-to-back including reserved op 11
    passthrough(MEM_NONE, 32'h1234, 5'd5, 1'b1);
    idle();
    passthrough(MEM_NONE, 32'hCAFE_0001, 5'd1, 1'b0);
    passthrough(2'b11, 32'hCAFE_0002, 5'd31, 1'b1);
    idle();

    // Load with 3-cycle memory, zero-wait store, load without reg_write
    mem_access(MEM_LOAD, 32'h100, 32'h0, 5'd7, 1'b1, 2, 32'hDEAD_BEEF, 1'b0);
    mem_access(MEM_STORE, 32'h200, 32'hA5A5_A5A5, 5'd3, 1'b1, 0, 32'h0, 1'b0);
    mem_access(MEM_LOAD, 32'h104, 32'h0, 5'd12, 1'b0, 1, 32'h0BAD_F00D, 1'b0);

    // Stall release: bundle held during the access is taken when stall drops
    mem_access(MEM_STORE, 32'h204, 32'h0123_4567, 5'd4, 1'b1, 1, 32'h0, 1'b1);

    // Misaligned load and store
    misaligned(MEM_LOAD, 32'h102, 5'd6);
    misaligned(MEM_STORE, 32'h201, 5'd6);

    // Timeout, then a normal passthrough
    mem_access(MEM_LOAD, 32'h300, 32'h0, 5'd8, 1'b1, -1, 32'h0, 1'b0);
    passthrough(MEM_NONE, 32'h7777, 5'd10, 1'b1);
    idle();

    // Ack in the last allowed cycle wins over timeout
    mem_access(MEM_LOAD, 32'h308, 32'h0, 5'd11, 1'b1, TO - 1, 32'h600D_D00D, 1'b0);

    // Reset mid-access, then a stray ack in IDLE
    @(negedge clk);
    in_valid  = 1'b1;
    mem_op    = MEM_LOAD;
    ex_result = 32'h400;
    rd        = 5'd2;
    reg_write = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mem_op   = MEM_NONE;
    check("mid_stall", stall, 1'b1);
    check("mid_req", dmem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_req", dmem_req, 1'b0);
    check("async_stall", stall, 1'b0);
    check("async_wb", wb_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("stray_wb", wb_valid, 1'b0);
    check("stray_req", dmem_req, 1'b0);
    check("stray_stall", stall, 1'b0);
    passthrough(MEM_NONE, 32'h8888, 5'd13, 1'b1);
    idle();

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Consumes the registered `result` (address or ALU value), store data and control from the execute stage.
- Performs word loads and stores over a req/ack data-memory handshake.
- Presents a registered writeback bundle to the register file.
- Holds the upstream pipeline with `stall` while an access is outstanding.

Parameters:
- DATA_W, 32, data and address width
- TIMEOUT, 255, maximum cycles to wait for `dmem_ack` before aborting (1..1023)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute-stage bundle valid this cycle
- ex_result  in  DATA_W  execute result: byte address for load/store, value for non-memory ops
- store_data  in  DATA_W  store write data
- mem_op  in  2  00 none, 01 load word, 10 store word, 11 reserved (treated as none)
- rd  in  5  destination register
- reg_write  in  1  instruction writes `rd`
- stall  out  1  upstream must hold its bundle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  byte address, always word aligned when `dmem_req`=1
- dmem_wdata  out  DATA_W  write data
- dmem_rdata  in  DATA_W  read data, valid with `dmem_ack`
- dmem_ack  in  1  access complete
- wb_valid  out  1  writeback bundle valid (one-cycle pulse)
- wb_we  out  1  register-file write enable
- wb_rd  out  5  writeback register
- wb_data  out  DATA_W  writeback value
- err  out  2  one-cycle pulse: 01 misaligned, 10 timeout, 00 none

Behaviour:
- **Reset** (`reset`=0, async): state IDLE; all outputs 0, including `stall`, `dmem_*`, `wb_*` and `err`; timeout counter 0.
- **FSM states:** IDLE, ACCESS.
- **IDLE, in_valid=0:** next cycle `wb_valid`=0. No other action.
- **IDLE, in_valid=1, mem_op none/reserved:**
  - Next cycle: `wb_valid`=1, `wb_we`=`reg_write`, `wb_rd`=`rd`, `wb_data`=`ex_result`.
  - Latency 1. Remain in IDLE, so back-to-back non-memory ops run at full rate.
- **IDLE, in_valid=1, load/store with ex_result[1:0]≠0:**
  - No memory access.
  - Next cycle: `wb_valid`=1, `wb_we`=0, `err`=01.
- **IDLE, in_valid=1, aligned load/store:**
  - Next cycle: `dmem_req`=1, `dmem_we`=(op==store), `dmem_addr`=`ex_result`, `dmem_wdata`=`store_data`.
  - Latch `rd`, `reg_write` and the op; go to ACCESS; counter cleared.
- **ACCESS:**
  - `stall`=1 (combinational from state). Upstream inputs are ignored.
  - `dmem_*` outputs are held stable until ack.
- **ACCESS, dmem_ack=1** (legal in the first ACCESS cycle, i.e. zero wait):
  - Next cycle: `dmem_req`=0, state IDLE.
  - `wb_valid`=1, `wb_rd`=latched rd.
  - Load: `wb_we`=latched reg_write, `wb_data`=`dmem_rdata` sampled at ack.
  - Store: `wb_we`=0, `wb_data`=0.
- **ACCESS, no ack:**
  - Counter increments each cycle.
  - When counter reaches TIMEOUT-1 without ack: next cycle `dmem_req`=0, `wb_valid`=1, `wb_we`=0, `err`=10, state IDLE.
  - Ack in that same cycle wins over timeout.
- **Stray ack:** `dmem_ack` while in IDLE is ignored.
- **wb_valid / err:** every `wb_valid` and `err` assertion lasts exactly one cycle.
- **Reset mid-access:** `dmem_req` drops immediately (async). No writeback is produced and no error is flagged.
- **Stall release:** `stall` deasserts in the same cycle `wb_valid` rises. The upstream bundle presented that cycle is accepted.

Decomposition:
- Shared package (`mem_pkg`) holds:
  - MEM_NONE/LOAD/STORE op codes
  - ERR_NONE/MISALIGN/TIMEOUT codes
  - FSM state encoding
- No sub-module is natural. The timeout counter is inline.

Test Plan:
1. **Passthrough:** in_valid, op 00, ex_result=0x1234, rd=5, reg_write=1 → one cycle later wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, stall never 1.
2. **Load, 3-cycle memory:**
   - Stimulus: op 01, ex_result=0x100, rd=7; ack 3 cycles after req with rdata=0xDEADBEEF.
   - Response: dmem_addr=0x100, dmem_we=0, stall=1 for 3 cycles, then wb_data=0xDEADBEEF, wb_rd=7, wb_we=1.
3. **Zero-wait store:**
   - Stimulus: op 10, ex_result=0x200, store_data=0xA5A5A5A5; ack in first req cycle.
   - Response: dmem_we=1, dmem_wdata=0xA5A5A5A5, stall one cycle, wb_valid=1 with wb_we=0.
4. **Misaligned:** load at 0x102 → dmem_req never asserted, next cycle wb_valid=1, wb_we=0, err=01.
5. **Timeout:**
   - Stimulus: TIMEOUT=4, load at 0x300, ack never asserted.
   - Response: dmem_req high 4 cycles, then err=10, wb_we=0, stall released, next passthrough op completes normally.
6. **Reset mid-access:** reset low during ACCESS → dmem_req and stall 0 immediately, no wb_valid; after release a stray ack is ignored.
